rl_ram_1r1w_arbiter: RTL
========================

Name: rl_ram_1r1w_arbiter

Overview:
Shares one 1R1W RAM (registered read, 1-cycle latency, byte-enabled write) between NREQ requesters.
- Read port and write port each have an independent round-robin arbiter.
- Read responses are routed back to the requester that issued them.
- Same-cycle read/write to the same address is forwarded, so the read returns the newly written data.
- A built-in clear sequencer writes zero to the whole array after reset or on command.
- Sits between the RAM wrapper and its masters: CPU data port, DMA, debug.

Parameters:
ABITS, 10, RAM address width.
DBITS, 32, RAM data width; byte-enable width BEBITS=(DBITS+7)/8.
NREQ, 2, number of requesters (2..8).
CLEAR_ON_RESET, 1, 1 = start a clear sweep when reset is released; 0 = go straight to RUN.

Ports:
clk_i  in  1  clock, rising edge
rst_ni  in  1  asynchronous active-low reset
clear_i  in  1  one-cycle pulse that starts a clear sweep; sampled in RUN only
busy_o  out  1  high while clearing
wreq_i  in  NREQ  write request per requester
wack_o  out  NREQ  write grant, one-hot, same cycle as request
waddr_i  in  NREQ*ABITS  write address; slice i belongs to requester i
wdata_i  in  NREQ*DBITS  write data
wbe_i  in  NREQ*BEBITS  write byte enables
rreq_i  in  NREQ  read request
rack_o  out  NREQ  read grant, one-hot, same cycle
raddr_i  in  NREQ*ABITS  read address
rvalid_o  out  NREQ  read data valid, one-hot, one cycle after rack
rdata_o  out  DBITS  read data, shared by all requesters, qualified by rvalid_o
ram_waddr_o  out  ABITS  to RAM write address
ram_din_o  out  DBITS  to RAM write data
ram_we_o  out  1  to RAM write enable
ram_be_o  out  BEBITS  to RAM byte enables
ram_raddr_o  out  ABITS  to RAM read address
ram_dout_i  in  DBITS  from RAM registered read data

Behaviour:
Clock and reset:
- Single clock clk_i.
- rst_ni is asynchronous, active-low, and clears all flops.

Reset values:
- state=CLEAR if CLEAR_ON_RESET else RUN; clear counter 0.
- Both round-robin pointers 0.
- rvalid_o=0, forwarding flags 0.
- busy_o equals CLEAR_ON_RESET while in reset.
- wack_o/rack_o=0 and ram_we_o=0 during reset.

FSM:
- CLEAR:
  - ram_we_o=1, ram_waddr_o=cnt, ram_din_o=0, ram_be_o=all ones.
  - cnt increments every cycle.
  - At cnt=2^ABITS-1 the state goes to RUN and cnt returns to 0.
  - No acks are issued; busy_o=1. Requests are held off, not dropped.
- RUN:
  - clear_i=1 moves the state to CLEAR next cycle; grants continue normally that cycle.
  - A read acked in the cycle before a clear still gets its rvalid.

Arbitration (RUN only; read and write sides are independent and identical):
- Grant goes to the lowest index j >= ptr with req[j]=1, wrapping modulo NREQ.
- ack is combinational, one-hot or zero.
- On a grant, ptr <= j+1 mod NREQ. With no request, ptr holds.
- A requester holds req and its address/data until it sees ack; the transfer happens in the ack cycle.
- Write path: ram_we_o=|wack_o, and RAM write fields are muxed from the granted slice. With no grant, ram_we_o=0.
- Read path: ram_raddr_o is muxed from the granted slice. With no grant, ram_raddr_o holds its last value.

Read return:
- The grant index is registered; rvalid_o[idx]=1 in the next cycle.
- rdata_o = ram_dout_i unless forwarding applies.
- Back-to-back reads give one result per cycle.

Forwarding (RAM read-during-write output is undefined):
- Applies when the read and write are granted in the same cycle to the same address.
- Register wdata, wbe and a flag in that cycle.
- Next cycle, per byte: rdata_o byte = wdata byte if its be bit was set, else ram_dout_i byte.
- The same applies in CLEAR, but reads are never granted there, so it does not arise.

Boundaries:
- cnt wraps exactly at 2^ABITS-1.
- clear_i during CLEAR is ignored.
- Reset mid-sweep restarts per CLEAR_ON_RESET.
- NREQ=1 degenerates to a pass-through with 1-cycle-delayed rvalid.

Decomposition:
Package rl_ram_arb_pkg holds:
- state enum {ST_CLEAR, ST_RUN};
- a function returning the round-robin grant: req vector, ptr -> one-hot;
- a function converting one-hot to index.

Sub-module rl_rr_arbiter (params NREQ):
- Inputs: clk_i, rst_ni, req, en.
- Outputs: gnt one-hot, gnt_idx.
- Contains its own pointer.
- Instantiated twice, once for read and once for write.

Test Plan:
- Reset, CLEAR_ON_RESET=1, ABITS=4: busy_o high exactly 16 cycles, ram_we_o high with waddr 0..15 and din 0; then reading address 5 returns 0.
- NREQ=2, both rreq held for 4 cycles with addresses 3 and 7 (preloaded 0xA3, 0xA7): rack alternates 01,10,01,10; rvalid follows one cycle later with data 0xA3,0xA7,0xA3,0xA7.
- Same cycle, write address 9 data 0x11223344 be 0101 and read address 9 (old 0xAABBCCDD): next-cycle rdata_o=0xAA22CC44.
- clear_i in RUN with a read acked that cycle: that rvalid still fires; busy_o rises next cycle; a wreq held during the sweep is acked in the first RUN cycle.
- Assert rst_ni mid-sweep at cnt=7: outputs return to reset values immediately; after release the sweep restarts from 0.
- Write side, 3 requesters all held for 3 cycles: wack sequence 001,010,100; ram_be_o/din track the granted slice.

Source files
------------

// File: rtl/rl_ram_arb_pkg.sv
// Shared types and round-robin helpers for the 1R1W RAM arbiter.
package rl_ram_arb_pkg;

    // Largest supported requester count and the width of an index into it.
    localparam int RR_MAX   = 8;
    localparam int RR_IDX_W = 3;

    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_RUN   = 1'b1
    } state_e;

    // Round-robin pick: first requester at or after ptr, wrapping modulo n.
    // Vectors are RR_MAX wide; bits at or above n must be zero.
    function automatic logic [RR_MAX-1:0] rr_grant(input logic [RR_MAX-1:0]   req,
                                                   input logic [RR_IDX_W-1:0] ptr,
                                                   input int                  n);
        logic [RR_MAX-1:0] gnt;
        logic              found;
        int                j;
        gnt   = '0;
        found = 1'b0;
        for (int k = 0; k < RR_MAX; k++) begin
            j = (int'(ptr) + k) % n;
            if (k < n && !found && req[j]) begin
                gnt[j] = 1'b1;
                found  = 1'b1;
            end
        end
        return gnt;
    endfunction

    // One-hot (or zero) vector to binary index; zero maps to 0.
    function automatic logic [RR_IDX_W-1:0] oh_to_idx(input logic [RR_MAX-1:0] oh);
        logic [RR_IDX_W-1:0] idx;
        idx = '0;
        for (int i = 0; i < RR_MAX; i++) begin
            if (oh[i]) idx = idx | RR_IDX_W'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/rl_ram_1r1w_arbiter_rr.sv
// Round-robin arbiter with its own rotating priority pointer.
// The pointer moves just past the winner and holds while idle.
module rl_rr_arbiter
    import rl_ram_arb_pkg::*;
#(
    parameter  int NREQ = 2,
    localparam int IW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic [NREQ-1:0] req_i,
    input  logic            en_i,
    output logic [NREQ-1:0] gnt_o,
    output logic [IW-1:0]   gnt_idx_o
);

    logic [RR_IDX_W-1:0] ptr_q, ptr_d;
    logic [RR_MAX-1:0]   req_ext;
    logic [RR_MAX-1:0]   gnt_ext;
    logic [RR_IDX_W-1:0] idx;

    // Grant selection and pointer advance.
    always_comb begin
        req_ext             = '0;
        req_ext[NREQ-1:0]   = req_i;
        gnt_ext             = en_i ? rr_grant(req_ext, ptr_q, NREQ) : '0;
        idx                 = oh_to_idx(gnt_ext);
        gnt_o               = gnt_ext[NREQ-1:0];
        gnt_idx_o           = idx[IW-1:0];
        ptr_d               = ptr_q;
        if (|gnt_ext) begin
            ptr_d = (idx == RR_IDX_W'(NREQ - 1)) ? '0 : idx + RR_IDX_W'(1);
        end
    end

    // Priority pointer register.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) ptr_q <= '0;
        else         ptr_q <= ptr_d;
    end

endmodule

// File: rtl/rl_ram_1r1w_arbiter.sv
// Shares one registered-read 1R1W RAM between NREQ requesters, with
// independent read/write round-robin arbitration, read-after-write
// forwarding for same-cycle collisions, and a zero-fill clear sweep.
//
//   state    | meaning
//   ---------+-----------------------------------------------------------
//   ST_CLEAR | writing zero to address cnt each cycle; no grants; busy_o=1
//   ST_RUN   | normal arbitration; clear_i starts a new sweep
module rl_ram_1r1w_arbiter
    import rl_ram_arb_pkg::*;
#(
    parameter  int ABITS          = 10,
    parameter  int DBITS          = 32,
    parameter  int NREQ           = 2,
    parameter  int CLEAR_ON_RESET = 1,
    localparam int BEBITS         = (DBITS + 7) / 8,
    localparam int IW             = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic                   clear_i,
    output logic                   busy_o,
    input  logic [NREQ-1:0]        wreq_i,
    output logic [NREQ-1:0]        wack_o,
    input  logic [NREQ*ABITS-1:0]  waddr_i,
    input  logic [NREQ*DBITS-1:0]  wdata_i,
    input  logic [NREQ*BEBITS-1:0] wbe_i,
    input  logic [NREQ-1:0]        rreq_i,
    output logic [NREQ-1:0]        rack_o,
    input  logic [NREQ*ABITS-1:0]  raddr_i,
    output logic [NREQ-1:0]        rvalid_o,
    output logic [DBITS-1:0]       rdata_o,
    output logic [ABITS-1:0]       ram_waddr_o,
    output logic [DBITS-1:0]       ram_din_o,
    output logic                   ram_we_o,
    output logic [BEBITS-1:0]      ram_be_o,
    output logic [ABITS-1:0]       ram_raddr_o,
    input  logic [DBITS-1:0]       ram_dout_i
);

    localparam state_e ST_RESET = (CLEAR_ON_RESET != 0) ? ST_CLEAR : ST_RUN;

    state_e             state_q, state_d;
    logic [ABITS-1:0]   cnt_q, cnt_d;
    logic               arb_en;
    logic [NREQ-1:0]    wgnt, rgnt;
    logic [IW-1:0]      widx, ridx;
    logic [ABITS-1:0]   raddr_sel;
    logic [ABITS-1:0]   raddr_q;
    logic               fwd_hit;
    logic               rv_q;
    logic [IW-1:0]      ridx_q;
    logic               fwd_q;
    logic [DBITS-1:0]   fwd_data_q;
    logic [BEBITS-1:0]  fwd_be_q;

    // Grants are also suppressed while reset is asserted so nothing
    // reaches the RAM before the controller is live.
    assign arb_en = (state_q == ST_RUN) && rst_ni;
    assign busy_o = (state_q == ST_CLEAR);
    assign wack_o = wgnt;
    assign rack_o = rgnt;

    rl_rr_arbiter #(.NREQ(NREQ)) u_warb (
        .clk_i     (clk_i),
        .rst_ni    (rst_ni),
        .req_i     (wreq_i),
        .en_i      (arb_en),
        .gnt_o     (wgnt),
        .gnt_idx_o (widx)
    );

    rl_rr_arbiter #(.NREQ(NREQ)) u_rarb (
        .clk_i     (clk_i),
        .rst_ni    (rst_ni),
        .req_i     (rreq_i),
        .en_i      (arb_en),
        .gnt_o     (rgnt),
        .gnt_idx_o (ridx)
    );

    // Next-state logic for the clear sweep / run sequencer.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_CLEAR: begin
                cnt_d = cnt_q + ABITS'(1);
                if (cnt_q == '1) begin
                    state_d = ST_RUN;
                    cnt_d   = '0;
                end
            end
            ST_RUN: begin
                if (clear_i) begin
                    state_d = ST_CLEAR;
                    cnt_d   = '0;
                end
            end
            default: begin
                state_d = ST_RUN;
                cnt_d   = '0;
            end
        endcase
    end

    // Sequencer state and sweep counter.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= ST_RESET;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // RAM write port: sweep writes during CLEAR, granted slice during RUN.
    always_comb begin
        ram_we_o    = 1'b0;
        ram_waddr_o = '0;
        ram_din_o   = '0;
        ram_be_o    = '0;
        if (state_q == ST_CLEAR) begin
            ram_we_o    = rst_ni;
            ram_waddr_o = cnt_q;
            ram_be_o    = '1;
        end else if (|wgnt) begin
            ram_we_o    = 1'b1;
            ram_waddr_o = waddr_i[int'(widx)*ABITS +: ABITS];
            ram_din_o   = wdata_i[int'(widx)*DBITS +: DBITS];
            ram_be_o    = wbe_i[int'(widx)*BEBITS +: BEBITS];
        end
    end

    // RAM read address follows the granted slice and holds when idle.
    always_comb begin
        raddr_sel   = raddr_i[int'(ridx)*ABITS +: ABITS];
        ram_raddr_o = (|rgnt) ? raddr_sel : raddr_q;
        fwd_hit     = (|rgnt) && ram_we_o && (ram_waddr_o == raddr_sel);
    end

    // Read-return tracking and forwarding capture.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            raddr_q    <= '0;
            rv_q       <= 1'b0;
            ridx_q     <= '0;
            fwd_q      <= 1'b0;
            fwd_data_q <= '0;
            fwd_be_q   <= '0;
        end else begin
            if (|rgnt) raddr_q <= raddr_sel;
            rv_q       <= |rgnt;
            ridx_q     <= ridx;
            fwd_q      <= fwd_hit;
            fwd_data_q <= ram_din_o;
            fwd_be_q   <= ram_be_o;
        end
    end

    // Route the response to its requester; merge forwarded bytes.
    always_comb begin
        rvalid_o = '0;
        if (rv_q) rvalid_o[ridx_q] = 1'b1;
        for (int b = 0; b < DBITS; b++) begin
            rdata_o[b] = (fwd_q && fwd_be_q[b/8]) ? fwd_data_q[b] : ram_dout_i[b];
        end
    end

endmodule
